// File: rtl/alu_reservation_station_if.sv
// Decoder dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
// master = surrounding core, slave = the reservation station.
`ifndef TYPE_BIT
`define TYPE_BIT 6
`endif
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 5
`endif

interface alu_reservation_station_if #(
  parameter int DATA_W = 32
);
  logic                      dispatch_valid;
  logic [`TYPE_BIT-1:0]      dispatch_type;
  logic [`ROB_INDEX_BIT-1:0] dispatch_rob_id;
  logic [DATA_W-1:0]         dispatch_v1;
  logic                      dispatch_q1_busy;
  logic [`ROB_INDEX_BIT-1:0] dispatch_q1;
  logic [DATA_W-1:0]         dispatch_v2;
  logic                      dispatch_q2_busy;
  logic [`ROB_INDEX_BIT-1:0] dispatch_q2;
  logic                      rs_full;

  logic                      cdb_alu_ready;
  logic [`ROB_INDEX_BIT-1:0] cdb_alu_rob_id;
  logic [DATA_W-1:0]         cdb_alu_result;
  logic                      cdb_lsb_ready;
  logic [`ROB_INDEX_BIT-1:0] cdb_lsb_rob_id;
  logic [DATA_W-1:0]         cdb_lsb_result;

  logic                      alu_req;
  logic [`TYPE_BIT-1:0]      alu_type;
  logic [DATA_W-1:0]         alu_r1;
  logic [DATA_W-1:0]         alu_r2;
  logic [`ROB_INDEX_BIT-1:0] alu_rob_id;

  modport master (
    output dispatch_valid, dispatch_type, dispatch_rob_id,
    output dispatch_v1, dispatch_q1_busy, dispatch_q1,
    output dispatch_v2, dispatch_q2_busy, dispatch_q2,
    input  rs_full,
    output cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
    output cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result,
    input  alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
  );

  modport slave (
    input  dispatch_valid, dispatch_type, dispatch_rob_id,
    input  dispatch_v1, dispatch_q1_busy, dispatch_q1,
    input  dispatch_v2, dispatch_q2_busy, dispatch_q2,
    output rs_full,
    input  cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
    input  cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result,
    output alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until operands resolve, issues one ready op per cycle.
// Define RS_ISSUE_OLDEST_EN to issue the oldest ready entry instead of the lowest-index one.
`ifndef TYPE_BIT
`define TYPE_BIT 6
`endif
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 5
`endif

module alu_reservation_station #(
  parameter int RS_SIZE_BIT = 4,
  parameter int DATA_W      = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic clear,
  alu_reservation_station_if.slave rs
);
  localparam int RS_SIZE = 2 ** RS_SIZE_BIT;
  localparam int TW      = `TYPE_BIT;
  localparam int RW      = `ROB_INDEX_BIT;

  typedef logic [RS_SIZE_BIT-1:0] idx_t;

  logic [RS_SIZE-1:0] ent_busy;
  logic [TW-1:0]      ent_type [RS_SIZE];
  logic [RW-1:0]      ent_rob  [RS_SIZE];
  logic [DATA_W-1:0]  ent_v1   [RS_SIZE];
  logic [DATA_W-1:0]  ent_v2   [RS_SIZE];
  logic [RS_SIZE-1:0] ent_q1b;
  logic [RS_SIZE-1:0] ent_q2b;
  logic [RW-1:0]      ent_q1   [RS_SIZE];
  logic [RW-1:0]      ent_q2   [RS_SIZE];
`ifdef RS_ISSUE_OLDEST_EN
  // older[i][j] set means entry i was dispatched before entry j.
  logic [RS_SIZE-1:0] older [RS_SIZE];
`endif

  logic              vld_p1;
  logic [TW-1:0]     type_p1;
  logic [DATA_W-1:0] r1_p1;
  logic [DATA_W-1:0] r2_p1;
  logic [RW-1:0]     rob_p1;

  logic [RS_SIZE-1:0] ready;
  logic               rs_full_w;
  logic               iss_hit;
  idx_t               iss_idx;
  idx_t               free_idx;

  logic [RS_SIZE-1:0] w1b, w2b;
  logic [DATA_W-1:0]  w1v [RS_SIZE];
  logic [DATA_W-1:0]  w2v [RS_SIZE];
  logic               d1b, d2b;
  logic [DATA_W-1:0]  d1v, d2v;

  // Returns {still_waiting, value} after snooping both result buses.
  function automatic logic [DATA_W:0] wake(input logic wait_b, input logic [RW-1:0] tag,
                                           input logic [DATA_W-1:0] val);
    if (wait_b && rs.cdb_alu_ready && tag == rs.cdb_alu_rob_id)
      return {1'b0, rs.cdb_alu_result};
    if (wait_b && rs.cdb_lsb_ready && tag == rs.cdb_lsb_rob_id)
      return {1'b0, rs.cdb_lsb_result};
    return {wait_b, val};
  endfunction

  always_comb begin
    w1b = '0;
    w2b = '0;
    w1v = '{default: '0};
    w2v = '{default: '0};
    for (int i = 0; i < RS_SIZE; i++) begin
      {w1b[i], w1v[i]} = wake(ent_q1b[i], ent_q1[i], ent_v1[i]);
      {w2b[i], w2v[i]} = wake(ent_q2b[i], ent_q2[i], ent_v2[i]);
    end
    {d1b, d1v} = wake(rs.dispatch_q1_busy, rs.dispatch_q1, rs.dispatch_v1);
    {d2b, d2v} = wake(rs.dispatch_q2_busy, rs.dispatch_q2, rs.dispatch_v2);
  end

  assign ready     = ent_busy & ~ent_q1b & ~ent_q2b;
  assign rs_full_w = &ent_busy;

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_busy[i]) free_idx = idx_t'(i);
    end
  end

`ifdef RS_ISSUE_OLDEST_EN
  always_comb begin
    logic cand;
    cand    = 1'b0;
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      cand = ready[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (j != i && ready[j] && !older[i][j]) cand = 1'b0;
      end
      if (cand) begin
        iss_hit = 1'b1;
        iss_idx = idx_t'(i);
      end
    end
  end
`else
  always_comb begin
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_hit = 1'b1;
        iss_idx = idx_t'(i);
      end
    end
  end
`endif

  // Stage p0 -> p1: entry update, wakeup, dispatch write and issue register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ent_busy <= '0;
      vld_p1   <= 1'b0;
      type_p1  <= '0;
      r1_p1    <= '0;
      r2_p1    <= '0;
      rob_p1   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        ent_busy <= '0;
        vld_p1   <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_busy[i]) begin
            ent_q1b[i] <= w1b[i];
            ent_v1[i]  <= w1v[i];
            ent_q2b[i] <= w2b[i];
            ent_v2[i]  <= w2v[i];
          end
        end
        vld_p1 <= iss_hit;
        if (iss_hit) begin
          ent_busy[iss_idx] <= 1'b0;
          type_p1           <= ent_type[iss_idx];
          r1_p1             <= ent_v1[iss_idx];
          r2_p1             <= ent_v2[iss_idx];
          rob_p1            <= ent_rob[iss_idx];
        end
        // The free slot was idle before this edge, so it never collides with issue or wakeup.
        if (rs.dispatch_valid && !rs_full_w) begin
          ent_busy[free_idx] <= 1'b1;
          ent_type[free_idx] <= rs.dispatch_type;
          ent_rob[free_idx]  <= rs.dispatch_rob_id;
          ent_q1b[free_idx]  <= d1b;
          ent_v1[free_idx]   <= d1v;
          ent_q1[free_idx]   <= rs.dispatch_q1;
          ent_q2b[free_idx]  <= d2b;
          ent_v2[free_idx]   <= d2v;
          ent_q2[free_idx]   <= rs.dispatch_q2;
`ifdef RS_ISSUE_OLDEST_EN
          older[free_idx] <= '0;
          for (int j = 0; j < RS_SIZE; j++) begin
            if (j != int'(free_idx)) older[j][free_idx] <= 1'b1;
          end
`endif
        end
      end
    end
  end

  assign rs.rs_full    = rs_full_w;
  assign rs.alu_req    = vld_p1;
  assign rs.alu_type   = type_p1;
  assign rs.alu_r1     = r1_p1;
  assign rs.alu_r2     = r2_p1;
  assign rs.alu_rob_id = rob_p1;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an entry-list reference model.
`ifndef TYPE_BIT
`define TYPE_BIT 6
`endif
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 5
`endif

module tb_alu_reservation_station;
  localparam int TW = `TYPE_BIT;
  localparam int RW = `ROB_INDEX_BIT;
  localparam int N  = 16;
  localparam logic [TW-1:0] T_ADD = 1;
  localparam logic [TW-1:0] T_SUB = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clear  = 1'b0;

  alu_reservation_station_if rsif ();

  alu_reservation_station #(.RS_SIZE_BIT(4)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .clear (clear),
    .rs    (rsif)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain list of waiting ops with a dispatch sequence number.
  typedef struct {
    bit            busy;
    logic [TW-1:0] typ;
    logic [RW-1:0] rob;
    logic [31:0]   v1, v2;
    bit            w1, w2;
    logic [RW-1:0] q1, q2;
    int unsigned   age;
  } ent_t;

  ent_t          m [N];
  bit            mvalid  = 0;
  int unsigned   age_ctr = 0;
  logic          exp_req;
  logic [TW-1:0] exp_type;
  logic [31:0]   exp_r1, exp_r2;
  logic [RW-1:0] exp_rob;

  task automatic resolve(input bit w_in, input logic [RW-1:0] q, input logic [31:0] v_in,
                         output bit w_out, output logic [31:0] v_out);
    w_out = w_in;
    v_out = v_in;
    if (w_in && rsif.cdb_alu_ready && q == rsif.cdb_alu_rob_id) begin
      w_out = 0;
      v_out = rsif.cdb_alu_result;
    end else if (w_in && rsif.cdb_lsb_ready && q == rsif.cdb_lsb_rob_id) begin
      w_out = 0;
      v_out = rsif.cdb_lsb_result;
    end
  endtask

  task automatic model_step();
    int sel;
    int fr;
    bit full;
    bit tw;
    logic [31:0] tv;
    if (rst_in) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      exp_req = 0; exp_type = '0; exp_r1 = '0; exp_r2 = '0; exp_rob = '0;
      mvalid = 1;
      return;
    end
    if (!mvalid || !rdy_in) return;
    if (clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      exp_req = 0;
      return;
    end
    sel = -1; fr = -1; full = 1;
    for (int i = 0; i < N; i++) begin
      if (!m[i].busy) begin
        full = 0;
        if (fr < 0) fr = i;
      end else if (!m[i].w1 && !m[i].w2) begin
`ifdef RS_ISSUE_OLDEST_EN
        if (sel < 0 || m[i].age < m[sel].age) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    exp_req = (sel >= 0);
    if (sel >= 0) begin
      exp_type = m[sel].typ; exp_r1 = m[sel].v1; exp_r2 = m[sel].v2; exp_rob = m[sel].rob;
      m[sel].busy = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        resolve(m[i].w1, m[i].q1, m[i].v1, tw, tv); m[i].w1 = tw; m[i].v1 = tv;
        resolve(m[i].w2, m[i].q2, m[i].v2, tw, tv); m[i].w2 = tw; m[i].v2 = tv;
      end
    end
    if (rsif.dispatch_valid && !full) begin
      m[fr].busy = 1;
      m[fr].typ  = rsif.dispatch_type;
      m[fr].rob  = rsif.dispatch_rob_id;
      m[fr].q1   = rsif.dispatch_q1;
      m[fr].q2   = rsif.dispatch_q2;
      resolve(rsif.dispatch_q1_busy, rsif.dispatch_q1, rsif.dispatch_v1, tw, tv);
      m[fr].w1 = tw; m[fr].v1 = tv;
      resolve(rsif.dispatch_q2_busy, rsif.dispatch_q2, rsif.dispatch_v2, tw, tv);
      m[fr].w2 = tw; m[fr].v2 = tv;
      m[fr].age = age_ctr;
      age_ctr++;
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 0;
    return 1;
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the next edge will see.
  initial begin
    forever begin
      @(negedge clk_in);
      if (mvalid) begin
        chk("mdl_req", {31'd0, rsif.alu_req}, {31'd0, exp_req});
        chk("mdl_type", 32'(rsif.alu_type), 32'(exp_type));
        chk("mdl_r1", rsif.alu_r1, exp_r1);
        chk("mdl_r2", rsif.alu_r2, exp_r2);
        chk("mdl_rob", 32'(rsif.alu_rob_id), 32'(exp_rob));
        chk("mdl_full", {31'd0, rsif.rs_full}, {31'd0, model_full()});
      end
      model_step();
    end
  end

  task automatic idle_inputs();
    rsif.dispatch_valid = 0;
    rsif.cdb_alu_ready  = 0;
    rsif.cdb_lsb_ready  = 0;
    clear               = 0;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
    idle_inputs();
  endtask

  task automatic disp(input logic [TW-1:0] t, input logic [RW-1:0] rob,
                      input bit b1, input logic [RW-1:0] q1, input logic [31:0] v1,
                      input bit b2, input logic [RW-1:0] q2, input logic [31:0] v2);
    rsif.dispatch_valid   = 1;
    rsif.dispatch_type    = t;
    rsif.dispatch_rob_id  = rob;
    rsif.dispatch_q1_busy = b1;
    rsif.dispatch_q1      = q1;
    rsif.dispatch_v1      = v1;
    rsif.dispatch_q2_busy = b2;
    rsif.dispatch_q2      = q2;
    rsif.dispatch_v2      = v2;
  endtask

  task automatic bcast_alu(input logic [RW-1:0] tag, input logic [31:0] val);
    rsif.cdb_alu_ready = 1; rsif.cdb_alu_rob_id = tag; rsif.cdb_alu_result = val;
  endtask

  task automatic bcast_lsb(input logic [RW-1:0] tag, input logic [31:0] val);
    rsif.cdb_lsb_ready = 1; rsif.cdb_lsb_rob_id = tag; rsif.cdb_lsb_result = val;
  endtask

  task automatic rand_inputs();
    rst_in = ($urandom_range(0, 299) == 0);
    rdy_in = ($urandom_range(0, 9) != 0);
    clear  = ($urandom_range(0, 49) == 0);
    rsif.dispatch_valid   = ($urandom_range(0, 9) < 7);
    rsif.dispatch_type    = TW'($urandom);
    rsif.dispatch_rob_id  = RW'($urandom);
    rsif.dispatch_q1_busy = $urandom_range(0, 1);
    rsif.dispatch_q1      = RW'($urandom_range(0, 7));
    rsif.dispatch_v1      = $urandom;
    rsif.dispatch_q2_busy = $urandom_range(0, 1);
    rsif.dispatch_q2      = RW'($urandom_range(0, 7));
    rsif.dispatch_v2      = $urandom;
    rsif.cdb_alu_ready    = ($urandom_range(0, 9) < 4);
    rsif.cdb_alu_rob_id   = RW'($urandom_range(0, 7));
    rsif.cdb_alu_result   = $urandom;
    rsif.cdb_lsb_ready    = ($urandom_range(0, 9) < 4);
    rsif.cdb_lsb_rob_id   = RW'($urandom_range(0, 7));
    rsif.cdb_lsb_result   = $urandom;
    if (rsif.cdb_alu_ready && rsif.cdb_lsb_ready && rsif.cdb_alu_rob_id == rsif.cdb_lsb_rob_id)
      rsif.cdb_lsb_ready = 0;
  endtask

  initial begin
    idle_inputs();
    disp(T_ADD, '0, 0, '0, '0, 0, '0, '0);
    rsif.dispatch_valid = 0;
    bcast_alu('0, '0); bcast_lsb('0, '0);
    rsif.cdb_alu_ready = 0; rsif.cdb_lsb_ready = 0;
    rst_in = 1;
    repeat (3) cyc();
    rst_in = 0;
    chk("rst_req", {31'd0, rsif.alu_req}, 0);
    chk("rst_r1", rsif.alu_r1, 0);
    chk("rst_rob", 32'(rsif.alu_rob_id), 0);
    chk("rst_full", {31'd0, rsif.rs_full}, 0);

    // Resolved ADD: issues one edge after dispatch.
    disp(T_ADD, 2, 0, 0, 3, 0, 0, 5); cyc();
    chk("add_e1_req", {31'd0, rsif.alu_req}, 0);
    cyc();
    chk("add_req", {31'd0, rsif.alu_req}, 1);
    chk("add_type", 32'(rsif.alu_type), 32'(T_ADD));
    chk("add_r1", rsif.alu_r1, 3);
    chk("add_r2", rsif.alu_r2, 5);
    chk("add_rob", 32'(rsif.alu_rob_id), 2);
    cyc();
    chk("add_done_req", {31'd0, rsif.alu_req}, 0);
    chk("add_hold_r1", rsif.alu_r1, 3);

    // SUB waiting on tag 7, woken by the LSB bus.
    disp(T_SUB, 3, 1, 7, 0, 0, 0, 1); cyc();
    repeat (4) begin cyc(); chk("sub_wait_req", {31'd0, rsif.alu_req}, 0); end
    bcast_lsb(7, 32'h10); cyc();
    chk("sub_wake_req", {31'd0, rsif.alu_req}, 0);
    cyc();
    chk("sub_req", {31'd0, rsif.alu_req}, 1);
    chk("sub_type", 32'(rsif.alu_type), 32'(T_SUB));
    chk("sub_r1", rsif.alu_r1, 32'h10);
    chk("sub_r2", rsif.alu_r2, 1);
    chk("sub_rob", 32'(rsif.alu_rob_id), 3);

    // Dispatch bypass from a same-cycle ALU broadcast.
    disp(T_ADD, 5, 0, 0, 2, 1, 4, 0); bcast_alu(4, 9); cyc();
    chk("byp_e0_req", {31'd0, rsif.alu_req}, 0);
    cyc();
    chk("byp_req", {31'd0, rsif.alu_req}, 1);
    chk("byp_r1", rsif.alu_r1, 2);
    chk("byp_r2", rsif.alu_r2, 9);
    chk("byp_rob", 32'(rsif.alu_rob_id), 5);
    cyc();

    // Fill every entry, try a 17th, then wake entry 5.
    for (int i = 0; i < N; i++) begin
      disp(T_SUB, RW'(i), 1, RW'(16 + i), 32'(i), 0, 0, 32'(100 + i)); cyc();
    end
    chk("full_16", {31'd0, rsif.rs_full}, 1);
    disp(T_ADD, 20, 0, 0, 1, 0, 0, 1); cyc();
    chk("full_17", {31'd0, rsif.rs_full}, 1);
    cyc();
    chk("full17_noissue", {31'd0, rsif.alu_req}, 0);
    bcast_alu(21, 32'h55); cyc();
    chk("wake5_req", {31'd0, rsif.alu_req}, 0);
    chk("wake5_full", {31'd0, rsif.rs_full}, 1);
    cyc();
    chk("e5_req", {31'd0, rsif.alu_req}, 1);
    chk("e5_rob", 32'(rsif.alu_rob_id), 5);
    chk("e5_r1", rsif.alu_r1, 32'h55);
    chk("e5_r2", rsif.alu_r2, 105);
    chk("e5_full", {31'd0, rsif.rs_full}, 0);

    // Flush with a same-cycle dispatch; nothing may issue afterwards.
    clear = 1; cyc();
    chk("clr_full", {31'd0, rsif.rs_full}, 0);
    for (int i = 0; i < 3; i++) begin
      disp(T_ADD, RW'(i), 1, RW'(10 + i), 0, 0, 0, 0); cyc();
    end
    clear = 1; disp(T_ADD, 9, 0, 0, 1, 0, 0, 1); cyc();
    chk("clr2_full", {31'd0, rsif.rs_full}, 0);
    chk("clr2_req", {31'd0, rsif.alu_req}, 0);
    bcast_alu(10, 1); bcast_lsb(11, 2); cyc();
    chk("clr_b1_req", {31'd0, rsif.alu_req}, 0);
    bcast_alu(12, 3); cyc();
    repeat (3) begin cyc(); chk("clr_noissue", {31'd0, rsif.alu_req}, 0); end

    // Ordering: X lands in entry 3, Y in entry 1 after a two-cycle stall.
    disp(T_ADD, 12, 1, 30, 0, 0, 0, 0); cyc();
    disp(T_ADD, 13, 1, 29, 0, 0, 0, 1); cyc();
    disp(T_ADD, 14, 1, 29, 0, 0, 0, 2); cyc();
    bcast_alu(29, 32'h77); cyc();
    disp(T_SUB, 15, 0, 0, 32'h33, 0, 0, 32'h44); cyc();
    chk("ord_a_req", {31'd0, rsif.alu_req}, 1);
    chk("ord_a_rob", 32'(rsif.alu_rob_id), 13);
    chk("ord_a_r1", rsif.alu_r1, 32'h77);
    rdy_in = 0;
    repeat (2) begin
      disp(T_SUB, 16, 0, 0, 1, 0, 0, 1); bcast_alu(30, 32'hdead); cyc();
      chk("stall_req", {31'd0, rsif.alu_req}, 1);
      chk("stall_rob", 32'(rsif.alu_rob_id), 13);
    end
    rdy_in = 1;
    disp(T_SUB, 17, 0, 0, 32'h55, 0, 0, 32'h66); cyc();
    chk("ord_b_rob", 32'(rsif.alu_rob_id), 14);
    cyc();
`ifdef RS_ISSUE_OLDEST_EN
    chk("ord_c_rob", 32'(rsif.alu_rob_id), 15);
    chk("ord_c_r1", rsif.alu_r1, 32'h33);
    cyc();
    chk("ord_d_rob", 32'(rsif.alu_rob_id), 17);
`else
    chk("ord_c_rob", 32'(rsif.alu_rob_id), 17);
    chk("ord_c_r1", rsif.alu_r1, 32'h55);
    cyc();
    chk("ord_d_rob", 32'(rsif.alu_rob_id), 15);
`endif
    chk("ord_d_req", {31'd0, rsif.alu_req}, 1);
    cyc();
    chk("ord_end_req", {31'd0, rsif.alu_req}, 0);
    clear = 1; cyc();

    // Randomized traffic, checked by the model process.
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      cyc();
    end
    rst_in = 0; rdy_in = 1;
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side initiator for the integer ALU in the out-of-order core.
- Accepts dispatched arithmetic/branch/JALR micro-ops from the decoder, holds them until both source operands are available, and issues one ready op per cycle on the ALU request interface (req, inst_type, r1, r2, rob_id).
- Snoops the common data bus (ALU result and LSB result) to wake up waiting operands.
- Flushed by the ROB on misprediction.

Parameters:
- RS_SIZE_BIT, 4, log2 of entry count; RS_SIZE = 2**RS_SIZE_BIT entries.
- TYPE_BIT and ROB_INDEX_BIT are taken from the shared constants include, not parameters.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  ready; when low all state holds.
- clear  input  1  ROB flush, synchronous.
- dispatch_valid  input  1  new op this cycle.
- dispatch_type  input  TYPE_BIT  instruction type code.
- dispatch_rob_id  input  ROB_INDEX_BIT  destination ROB tag.
- dispatch_v1  input  32  operand 1 value, meaningful when dispatch_q1_busy=0.
- dispatch_q1_busy  input  1  operand 1 waits on dispatch_q1.
- dispatch_q1  input  ROB_INDEX_BIT  producer tag for operand 1.
- dispatch_v2  input  32  operand 2 value, meaningful when dispatch_q2_busy=0.
- dispatch_q2_busy  input  1  operand 2 waits on dispatch_q2.
- dispatch_q2  input  ROB_INDEX_BIT  producer tag for operand 2.
- rs_full  output  1  all entries busy.
- cdb_alu_ready  input  1  ALU result broadcast valid.
- cdb_alu_rob_id  input  ROB_INDEX_BIT  ALU result tag.
- cdb_alu_result  input  32  ALU result value.
- cdb_lsb_ready  input  1  load/store buffer result broadcast valid.
- cdb_lsb_rob_id  input  ROB_INDEX_BIT  LSB result tag.
- cdb_lsb_result  input  32  LSB result value.
- alu_req  output  1  issue valid (registered).
- alu_type  output  TYPE_BIT  issued type.
- alu_r1  output  32  issued operand 1.
- alu_r2  output  32  issued operand 2.
- alu_rob_id  output  ROB_INDEX_BIT  issued tag.

Behaviour:
- Entry state: busy, type, rob_id, v1, q1_busy, q1, v2, q2_busy, q2.
- An entry is ready when busy=1, q1_busy=0 and q2_busy=0.
- Reset (rst_in=1 at an edge):
  - All entries have busy=0.
  - alu_req=0; alu_type, alu_r1, alu_r2 and alu_rob_id are 0.
  - rst_in has priority over rdy_in and clear.
- rdy_in=0: no state or output register changes. Dispatch and CDB inputs in that cycle are ignored.
- clear=1 (with rdy_in=1):
  - All busy bits go to 0 and alu_req goes to 0 at the edge.
  - Same-cycle dispatch and issue are discarded.
- Dispatch:
  - If dispatch_valid=1 and rs_full=0, the op is written into the lowest-index entry free before the edge.
  - dispatch_valid with rs_full=1 is ignored; the dispatcher must not do this.
- rs_full is combinational from registered state: all busy.
  - An entry freed by issue at edge k is usable for dispatch only from edge k+1.
- Wakeup: on every active edge, for every busy entry and for the entry being dispatched:
  - If q1_busy and cdb_alu_ready and q1==cdb_alu_rob_id, then v1<=cdb_alu_result and q1_busy<=0. Same rule for the LSB bus and for operand 2.
  - Both operands may wake in the same edge, from the same bus or from different buses.
- Dispatch bypass: a dispatched operand whose tag matches a same-cycle CDB broadcast is stored already resolved, with the broadcast value.
- Issue:
  - At each active edge, choose the lowest-index entry that is ready before the edge.
  - Set alu_req<=1, drive its fields onto alu_type, alu_r1, alu_r2 and alu_rob_id, and set busy<=0.
  - If no entry is ready, alu_req<=0 and the data outputs hold.
- Latency:
  - An op dispatched at edge t with both operands resolved issues at edge t+1; the ALU produces its result at edge t+2.
  - An operand woken at edge t makes its entry eligible at edge t+1. Wakeup does not forward into the issue mux in the same cycle.
- At most one dispatch and one issue per cycle; these may target different entries in the same edge.

Optional Feature:
- Macro: RS_ISSUE_OLDEST_EN.
- Defined: issue selects the ready entry dispatched earliest (age order kept by an age matrix or equivalent), regardless of index.
- Undefined: lowest-index ready entry. All other behaviour is identical.

Test Plan:
- Reset, then dispatch ADD v1=3, v2=5, both resolved, rob 2 at edge 1 -> alu_req=1, type ADD, r1=3, r2=5, rob_id=2 after edge 2; alu_req=0 after edge 3.
- Dispatch SUB with q1_busy, q1=7, v2=1. Hold 4 cycles with no issue. Then broadcast cdb_lsb rob 7 value 0x10 -> issues r1=0x10, r2=1 one edge later.
- Dispatch an op with q2=4 in the same cycle that cdb_alu broadcasts rob 4 value 9 -> stored resolved; issues next edge with r2=9.
- Fill all 16 entries with unresolved ops -> rs_full=1; a 17th dispatch is ignored. Broadcast wakes entry 5 -> it issues and rs_full drops on the following cycle.
- With 3 pending ops, assert clear together with dispatch_valid -> rs_full=0, alu_req=0, and no issue occurs afterwards even after matching broadcasts.
- Resolved ops dispatched into entries 3 then 1, with rdy_in low for 2 cycles between them -> state held. Entry 1 issues first without the macro; entry 3 issues first with RS_ISSUE_OLDEST_EN.
